// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the Phase-1 hardwired control sequencer:
//   - state_t        : one state per control step (IDLE, T0..T6, ERR)
//   - instr_class_t  : instruction classes the sequencer knows how to run
//   - OP_*           : opcodes of every supported instruction
//   - IR_*           : bit positions of the IR fields
//   - classify()     : maps an opcode onto its instruction class
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    CLS_ILLEGAL,
    CLS_ALU,
    CLS_MULDIV,
    CLS_UNARY
  } instr_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  // Anything not listed falls into CLS_ILLEGAL, which sends T3 to ERR.
  function automatic instr_class_t classify(input logic [4:0] op);
    instr_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  cls = CLS_ALU;
      OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
      OP_NEG, OP_NOT:                 cls = CLS_UNARY;
      default:                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// ---------------------------------------------------------------------------
// reg_sel_decoder
// Turns a 4-bit register index into a one-hot R0..R15 select.
// Ports:
//   i_idx    : register number 0..15
//   i_en     : when low the output is all zero
//   o_onehot : one-hot select, bit n drives register Rn
// ---------------------------------------------------------------------------
module reg_sel_decoder (
  input  logic [3:0]  i_idx,
  input  logic        i_en,
  output logic [15:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// alu_instr_sequencer
// Hardwired control FSM for the Phase-1 datapath. A start pulse in IDLE
// fetches one instruction (PC -> MAR -> MDR -> IR), decodes it, and sequences
// the register/ALU/Z/HI/LO strobes to execute it, one state per clock.
// Ports:
//   i_clock, i_clear        : clock (rising edge), async active-low reset
//   i_start                 : begin one instruction (only looked at in IDLE)
//   i_ir[31:0]              : datapath IR; op [31:27], Ra [26:23], Rb [22:19],
//                             Rc [18:15]
//   i_mem_ready             : memory read data valid
//   o_busy, o_done          : in-flight flag, one-cycle completion pulse
//   o_illegal_op            : with done, unsupported opcode
//   o_mem_timeout           : with done, memory never answered
//   o_pc_out .. o_lo_in     : single-bit datapath strobes
//   o_reg_out_en/o_reg_in_en: one-hot register enables (or zero)
//   o_alu_opcode            : ALU select, IDLE_OPCODE when not operating
// ---------------------------------------------------------------------------
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [4:0] IDLE_OPCODE = 5'b00000
) (
  input  logic        i_clock,
  input  logic        i_clear,
  input  logic        i_start,
  input  logic [31:0] i_ir,
  input  logic        i_mem_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_illegal_op,
  output logic        o_mem_timeout,
  output logic        o_pc_out,
  output logic        o_mar_in,
  output logic        o_inc_pc,
  output logic        o_z_in,
  output logic        o_zlow_out,
  output logic        o_zhigh_out,
  output logic        o_pc_in,
  output logic        o_read,
  output logic        o_mdr_in,
  output logic        o_mdr_out,
  output logic        o_ir_in,
  output logic        o_y_in,
  output logic        o_hi_in,
  output logic        o_lo_in,
  output logic [15:0] o_reg_out_en,
  output logic [15:0] o_reg_in_en,
  output logic [4:0]  o_alu_opcode
);

  localparam int         CW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_waitCnt;
  logic          r_errTimeout;
  logic [4:0]    r_opcode;
  logic [3:0]    r_ra;
  logic [3:0]    r_rb;
  logic [3:0]    r_rc;

  logic [4:0]    w_op;
  logic [3:0]    w_ra;
  logic [3:0]    w_rb;
  logic [3:0]    w_rc;
  instr_class_t  w_class;
  logic          w_outEn;
  logic [3:0]    w_outIdx;
  logic          w_inEn;
  logic [3:0]    w_inIdx;
  logic          w_unusedIrLow;

  assign w_unusedIrLow = ^i_ir[IR_RC_LSB-1:0];

  // IR is loaded at the end of T2, so during T3 the fields are read straight
  // from the IR; from T4 on the copies latched at the end of T3 are used.
  always_comb begin
    if (r_state == S_T3) begin
      w_op = i_ir[IR_OP_MSB:IR_OP_LSB];
      w_ra = i_ir[IR_RA_MSB:IR_RA_LSB];
      w_rb = i_ir[IR_RB_MSB:IR_RB_LSB];
      w_rc = i_ir[IR_RC_MSB:IR_RC_LSB];
    end else begin
      w_op = r_opcode;
      w_ra = r_ra;
      w_rb = r_rb;
      w_rc = r_rc;
    end
  end

  assign w_class = classify(w_op);

  // State register plus the T1 wait counter, error kind and IR field latch.
  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_state      <= S_IDLE;
      r_waitCnt    <= '0;
      r_errTimeout <= 1'b0;
      r_opcode     <= '0;
      r_ra         <= '0;
      r_rb         <= '0;
      r_rc         <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_T1: begin
          if (!i_mem_ready) begin
            r_waitCnt <= r_waitCnt + CNT_ONE;
          end
          r_errTimeout <= 1'b1;
        end
        S_T2: begin
          r_waitCnt <= '0;
        end
        S_T3: begin
          r_opcode     <= w_op;
          r_ra         <= w_ra;
          r_rb         <= w_rb;
          r_rc         <= w_rc;
          r_errTimeout <= 1'b0;
        end
        S_ERR: begin
          r_waitCnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and Moore output decode. Only T1 looks at i_mem_ready and only
  // IDLE at i_start, and both only for the next state, never for outputs.
  always_comb begin
    w_nextState   = r_state;
    o_done        = 1'b0;
    o_illegal_op  = 1'b0;
    o_mem_timeout = 1'b0;
    o_pc_out      = 1'b0;
    o_mar_in      = 1'b0;
    o_inc_pc      = 1'b0;
    o_z_in        = 1'b0;
    o_zlow_out    = 1'b0;
    o_zhigh_out   = 1'b0;
    o_pc_in       = 1'b0;
    o_read        = 1'b0;
    o_mdr_in      = 1'b0;
    o_mdr_out     = 1'b0;
    o_ir_in       = 1'b0;
    o_y_in        = 1'b0;
    o_hi_in       = 1'b0;
    o_lo_in       = 1'b0;
    o_alu_opcode  = IDLE_OPCODE;
    w_outEn       = 1'b0;
    w_outIdx      = '0;
    w_inEn        = 1'b0;
    w_inIdx       = '0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nextState = S_T0;
        end
      end

      S_T0: begin
        o_pc_out    = 1'b1;
        o_mar_in    = 1'b1;
        o_inc_pc    = 1'b1;
        o_z_in      = 1'b1;
        w_nextState = S_T1;
      end

      // The counter is zero on entry, so pc_in only fires on the first cycle
      // even while the read is being held for a slow memory.
      S_T1: begin
        o_zlow_out = 1'b1;
        o_read     = 1'b1;
        o_mdr_in   = 1'b1;
        o_pc_in    = (r_waitCnt == '0);
        if (i_mem_ready) begin
          w_nextState = S_T2;
        end else if (r_waitCnt == CNT_LAST) begin
          w_nextState = S_ERR;
        end
      end

      S_T2: begin
        o_mdr_out   = 1'b1;
        o_ir_in     = 1'b1;
        w_nextState = S_T3;
      end

      S_T3: begin
        case (w_class)
          CLS_ALU: begin
            w_outEn     = 1'b1;
            w_outIdx    = w_rb;
            o_y_in      = 1'b1;
            w_nextState = S_T4;
          end
          CLS_MULDIV: begin
            w_outEn     = 1'b1;
            w_outIdx    = w_ra;
            o_y_in      = 1'b1;
            w_nextState = S_T4;
          end
          CLS_UNARY: begin
            w_outEn      = 1'b1;
            w_outIdx     = w_rb;
            o_z_in       = 1'b1;
            o_alu_opcode = w_op;
            w_nextState  = S_T5;
          end
          default: begin
            w_nextState = S_ERR;
          end
        endcase
      end

      S_T4: begin
        w_outEn      = 1'b1;
        w_outIdx     = (w_class == CLS_MULDIV) ? w_rb : w_rc;
        o_z_in       = 1'b1;
        o_alu_opcode = w_op;
        w_nextState  = S_T5;
      end

      S_T5: begin
        o_zlow_out = 1'b1;
        if (w_class == CLS_MULDIV) begin
          o_lo_in     = 1'b1;
          w_nextState = S_T6;
        end else begin
          w_inEn      = 1'b1;
          w_inIdx     = w_ra;
          o_done      = 1'b1;
          w_nextState = S_IDLE;
        end
      end

      S_T6: begin
        o_zhigh_out = 1'b1;
        o_hi_in     = 1'b1;
        o_done      = 1'b1;
        w_nextState = S_IDLE;
      end

      S_ERR: begin
        o_done        = 1'b1;
        o_mem_timeout = r_errTimeout;
        o_illegal_op  = !r_errTimeout;
        w_nextState   = S_IDLE;
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  assign o_busy = (r_state != S_IDLE);

  reg_sel_decoder u_outDecoder (
    .i_idx    (w_outIdx),
    .i_en     (w_outEn),
    .o_onehot (o_reg_out_en)
  );

  reg_sel_decoder u_inDecoder (
    .i_idx    (w_inIdx),
    .i_en     (w_inEn),
    .o_onehot (o_reg_in_en)
  );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_instr_sequencer
// Directed bench for the hardwired sequencer. Each instruction pushes its
// hand-built per-cycle output pattern into a queue; a monitor pops one entry
// for every busy cycle and compares the full strobe/enable/flag vector.
// ---------------------------------------------------------------------------
module tb_alu_instr_sequencer;

  typedef struct packed {
    logic        pcOut;
    logic        marIn;
    logic        incPc;
    logic        zIn;
    logic        zlowOut;
    logic        zhighOut;
    logic        pcIn;
    logic        read;
    logic        mdrIn;
    logic        mdrOut;
    logic        irIn;
    logic        yIn;
    logic        hiIn;
    logic        loIn;
    logic [15:0] regOutEn;
    logic [15:0] regInEn;
    logic [4:0]  aluOpcode;
    logic        done;
    logic        illegalOp;
    logic        memTimeout;
  } obs_t;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] ir;
  logic        memReady;
  logic        busy, done, illegalOp, memTimeout;
  logic        pcOut, marIn, incPc, zIn, zlowOut, zhighOut, pcIn, read;
  logic        mdrIn, mdrOut, irIn, yIn, hiIn, loIn;
  logic [15:0] regOutEn, regInEn;
  logic [4:0]  aluOpcode;
  obs_t        actObs;

  obs_t        expQ[$];
  string       nameQ[$];
  int          errors = 0;
  int          checks = 0;

  alu_instr_sequencer #(
    .MEM_TIMEOUT (15),
    .IDLE_OPCODE (5'b00000)
  ) dut (
    .i_clock       (clock),
    .i_clear       (clear),
    .i_start       (start),
    .i_ir          (ir),
    .i_mem_ready   (memReady),
    .o_busy        (busy),
    .o_done        (done),
    .o_illegal_op  (illegalOp),
    .o_mem_timeout (memTimeout),
    .o_pc_out      (pcOut),
    .o_mar_in      (marIn),
    .o_inc_pc      (incPc),
    .o_z_in        (zIn),
    .o_zlow_out    (zlowOut),
    .o_zhigh_out   (zhighOut),
    .o_pc_in       (pcIn),
    .o_read        (read),
    .o_mdr_in      (mdrIn),
    .o_mdr_out     (mdrOut),
    .o_ir_in       (irIn),
    .o_y_in        (yIn),
    .o_hi_in       (hiIn),
    .o_lo_in       (loIn),
    .o_reg_out_en  (regOutEn),
    .o_reg_in_en   (regInEn),
    .o_alu_opcode  (aluOpcode)
  );

  assign actObs = {pcOut, marIn, incPc, zIn, zlowOut, zhighOut, pcIn, read,
                   mdrIn, mdrOut, irIn, yIn, hiIn, loIn, regOutEn, regInEn,
                   aluOpcode, done, illegalOp, memTimeout};

  // 10-unit clock period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Monitor: every busy cycle must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (busy) begin
        obs_t  e;
        string n;
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL extra_busy_cycle: got %h, required no busy cycle", actObs);
        end else begin
          e = expQ.pop_front();
          n = nameQ.pop_front();
          if (actObs !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", n, actObs, e);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'b0};
  endfunction

  function automatic obs_t blank();
    obs_t o;
    o = '0;
    return o;
  endfunction

  task automatic pushExp(input string n, input obs_t o);
    expQ.push_back(o);
    nameQ.push_back(n);
  endtask

  // T0, T1 (first cycle plus nWait held cycles) and T2 are common to all.
  task automatic pushFetch(input string tag, input int nWait);
    obs_t o;
    o = blank(); o.pcOut = 1; o.marIn = 1; o.incPc = 1; o.zIn = 1;
    pushExp({tag, "_T0"}, o);
    o = blank(); o.zlowOut = 1; o.read = 1; o.mdrIn = 1; o.pcIn = 1;
    pushExp({tag, "_T1"}, o);
    for (int i = 0; i < nWait; i++) begin
      o = blank(); o.zlowOut = 1; o.read = 1; o.mdrIn = 1;
      pushExp({tag, "_T1wait"}, o);
    end
    o = blank(); o.mdrOut = 1; o.irIn = 1;
    pushExp({tag, "_T2"}, o);
  endtask

  task automatic pushAlu(input string tag, input logic [4:0] op, input int ra,
                         input int rb, input int rc);
    obs_t o;
    o = blank(); o.regOutEn = 16'(1 << rb); o.yIn = 1;
    pushExp({tag, "_T3"}, o);
    o = blank(); o.regOutEn = 16'(1 << rc); o.zIn = 1; o.aluOpcode = op;
    pushExp({tag, "_T4"}, o);
    o = blank(); o.zlowOut = 1; o.regInEn = 16'(1 << ra); o.done = 1;
    pushExp({tag, "_T5"}, o);
  endtask

  task automatic checkOutput(input string n, input logic [63:0] got,
                             input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", n, got, want);
    end
  endtask

  // Waits (bounded) for the instruction to retire, then confirms that every
  // queued cycle was consumed.
  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("[TB] FAIL %s_retire: got busy=1 after %0d cycles, required busy=0", tag, n);
    end
    checkOutput({tag, "_leftover"}, 64'(expQ.size()), 64'd0);
    expQ.delete();
    nameQ.delete();
  endtask

  task automatic applyStimulus(input logic [31:0] irVal);
    ir       = irVal;
    memReady = 1'b1;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  initial begin
    obs_t o;
    clear    = 1'b0;
    start    = 1'b0;
    ir       = '0;
    memReady = 1'b1;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_outputs", 64'(actObs), 64'(blank()));
    checkOutput("reset_busy", 64'(busy), 64'd0);
    clear = 1'b1;
    @(posedge clock); #1;
    checkOutput("idle_busy", 64'(busy), 64'd0);

    // add R4 = R3 + R7
    pushFetch("add", 0);
    pushAlu("add", 5'b00011, 4, 3, 7);
    applyStimulus(mkIr(5'b00011, 4'd4, 4'd3, 4'd7));
    waitIdle("add");

    // mul Ra=2, Rb=5
    pushFetch("mul", 0);
    o = blank(); o.regOutEn = 16'h0004; o.yIn = 1;                       pushExp("mul_T3", o);
    o = blank(); o.regOutEn = 16'h0020; o.zIn = 1; o.aluOpcode = 5'b01111; pushExp("mul_T4", o);
    o = blank(); o.zlowOut = 1; o.loIn = 1;                                pushExp("mul_T5", o);
    o = blank(); o.zhighOut = 1; o.hiIn = 1; o.done = 1;                   pushExp("mul_T6", o);
    applyStimulus(mkIr(5'b01111, 4'd2, 4'd5, 4'd0));
    waitIdle("mul");

    // div Ra=14, Rb=0
    pushFetch("div", 0);
    o = blank(); o.regOutEn = 16'h4000; o.yIn = 1;                       pushExp("div_T3", o);
    o = blank(); o.regOutEn = 16'h0001; o.zIn = 1; o.aluOpcode = 5'b10000; pushExp("div_T4", o);
    o = blank(); o.zlowOut = 1; o.loIn = 1;                                pushExp("div_T5", o);
    o = blank(); o.zhighOut = 1; o.hiIn = 1; o.done = 1;                   pushExp("div_T6", o);
    applyStimulus(mkIr(5'b10000, 4'd14, 4'd0, 4'd9));
    waitIdle("div");

    // neg R1 = -R9, skips T4
    pushFetch("neg", 0);
    o = blank(); o.regOutEn = 16'h0200; o.zIn = 1; o.aluOpcode = 5'b10001; pushExp("neg_T3", o);
    o = blank(); o.zlowOut = 1; o.regInEn = 16'h0002; o.done = 1;          pushExp("neg_T5", o);
    applyStimulus(mkIr(5'b10001, 4'd1, 4'd9, 4'd0));
    waitIdle("neg");

    // or R15 = R0 | R15 (boundary register numbers)
    pushFetch("or", 0);
    pushAlu("or", 5'b01011, 15, 0, 15);
    applyStimulus(mkIr(5'b01011, 4'd15, 4'd0, 4'd15));
    waitIdle("or");

    // and R6 = R6 & R6 with memory slow for 3 T1 cycles
    pushFetch("andw", 3);
    pushAlu("andw", 5'b01010, 6, 6, 6);
    ir       = mkIr(5'b01010, 4'd6, 4'd6, 4'd6);
    memReady = 1'b0;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    repeat (3) @(posedge clock);
    #1;
    memReady = 1'b1;
    waitIdle("andw");

    // memory never answers: 15 T1 cycles, then ERR with mem_timeout
    pushFetch("tmo", 14);
    void'(expQ.pop_back());
    void'(nameQ.pop_back());
    o = blank(); o.done = 1; o.memTimeout = 1;
    pushExp("tmo_ERR", o);
    ir       = mkIr(5'b00011, 4'd1, 4'd2, 4'd3);
    memReady = 1'b0;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    waitIdle("tmo");
    memReady = 1'b1;

    // illegal opcode, with start held high across the busy window
    pushFetch("ill", 0);
    pushExp("ill_T3", blank());
    o = blank(); o.done = 1; o.illegalOp = 1;
    pushExp("ill_ERR", o);
    ir    = mkIr(5'b11111, 4'd3, 4'd3, 4'd3);
    start = 1'b1;
    repeat (5) begin
      @(posedge clock); #1;
    end
    start = 1'b0;
    waitIdle("ill");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checkOutput("ill_no_restart", 64'(busy), 64'd0);
    end

    // asynchronous reset in the middle of T4
    pushFetch("rst", 0);
    o = blank(); o.regOutEn = 16'h0008; o.yIn = 1;
    pushExp("rst_T3", o);
    applyStimulus(mkIr(5'b00011, 4'd4, 4'd3, 4'd7));
    repeat (4) @(posedge clock);
    #1;
    clear = 1'b0;
    #1;
    checkOutput("midreset_outputs", 64'(actObs), 64'(blank()));
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    checkOutput("midreset_no_done", 64'({busy, done}), 64'd0);
    clear = 1'b1;
    checkOutput("midreset_leftover", 64'(expQ.size()), 64'd0);
    expQ.delete();
    nameQ.delete();

    // normal run after the reset
    pushFetch("post", 0);
    pushAlu("post", 5'b00100, 4, 3, 7);
    applyStimulus(mkIr(5'b00100, 4'd4, 4'd3, 4'd7));
    waitIdle("post");

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
